booth_r4_multiplier: RTL and testbench

Parametrised sequential radix-4 Booth multiplier. It is the successor to the 8-bit shift-add multiplier: the operand width is generic, signed and unsigned operation is selected per transaction, and it retires two multiplier bits per cycle. It accepts operands on a start handshake, iterates one Booth digit per clock, then presents a registered full-width product with a one-cycle done pulse. It is intended for the MIPS datapath mult/multu path and for standalone arithmetic units.

---
 rtl/booth_r4_multiplier.sv | 205 ++++++++++++++++++++
 tb/tb_booth_r4_multiplier.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier with a generic operand width.
// One Booth digit (two multiplier bits) is retired per clock. Operands are
// widened by two bits at accept time (sign- or zero-extended), so a single
// signed datapath serves both signed and unsigned transactions. The product
// register is loaded only on the completion edge, and done pulses for one
// cycle at that point.
module booth_r4_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    // Extended operand width, width of the adder, and full accumulator width.
    localparam int EXT_W = WIDTH + 2;
    localparam int SUM_W = WIDTH + 4;
    localparam int ACC_W = 2 * WIDTH + 4;
    // Number of Booth digits, and the counter width needed to hold it.
    localparam int N_DIGITS = (WIDTH + 2) / 2;
    localparam int CNT_W = $clog2(N_DIGITS + 1);

    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(N_DIGITS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Operand widths that are odd or too narrow are rejected at elaboration.
    generate
        if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("booth_r4_multiplier: WIDTH must be even and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Widen an operand by two bits: sign-extend in signed mode, else zero-extend.
    function automatic logic [EXT_W-1:0] extend_operand(
        input logic [WIDTH-1:0] value,
        input logic             sign_mode
    );
        logic fill;
        fill = sign_mode & value[WIDTH-1];
        return {fill, fill, value};
    endfunction

    // Select the Booth multiple for one digit {b1, b0, b-1}; range is -2M..+2M.
    function automatic logic [SUM_W-1:0] booth_multiple(
        input logic [2:0]       digit_bits,
        input logic [SUM_W-1:0] m
    );
        logic [SUM_W-1:0] result;
        logic [SUM_W-1:0] m_x2;
        m_x2 = {m[SUM_W-2:0], 1'b0};
        case (digit_bits)
            3'b000, 3'b111: result = {SUM_W{1'b0}};
            3'b001, 3'b010: result = m;
            3'b011:         result = m_x2;
            3'b100:         result = {SUM_W{1'b0}} - m_x2;
            3'b101, 3'b110: result = {SUM_W{1'b0}} - m;
            default:        result = {SUM_W{1'b0}};
        endcase
        return result;
    endfunction

    state_t             state_r;
    state_t             next_state_s;

    // Latched, extended multiplicand.
    logic [EXT_W-1:0]   mcand_r;
    // Accumulator: upper EXT_W bits hold the running partial sum, lower EXT_W
    // bits start as the extended multiplier and fill with product bits as the
    // pair shifts right.
    logic [ACC_W-1:0]   acc_r;
    logic               y_m1_r;
    logic [CNT_W-1:0]   cnt_r;

    logic [2*WIDTH-1:0] product_r;
    logic               busy_r;
    logic               done_r;

    logic               accept_s;
    logic               finish_s;
    logic               last_s;
    logic [EXT_W-1:0]   hi_s;
    logic [EXT_W-1:0]   lo_s;
    logic [SUM_W-1:0]   m_wide_s;
    logic [SUM_W-1:0]   hi_wide_s;
    logic [SUM_W-1:0]   sum_s;
    logic [ACC_W-1:0]   acc_step_s;
    logic               y_m1_step_s;

    assign product = product_r;
    assign busy    = busy_r;
    assign done    = done_r;

    // One Booth step: add the selected multiple into the upper half, then
    // arithmetic-shift the accumulator/multiplier pair right by two.
    always_comb begin
        hi_s        = acc_r[ACC_W-1:EXT_W];
        lo_s        = acc_r[EXT_W-1:0];
        m_wide_s    = {{2{mcand_r[EXT_W-1]}}, mcand_r};
        hi_wide_s   = {{2{hi_s[EXT_W-1]}}, hi_s};
        sum_s       = hi_wide_s + booth_multiple({lo_s[1:0], y_m1_r}, m_wide_s);
        // sum_s >>> 2 always fits back in EXT_W bits, so the top two bits drop.
        acc_step_s  = {sum_s[SUM_W-1:2], sum_s[1:0], lo_s[EXT_W-1:2]};
        y_m1_step_s = lo_s[1];
        last_s      = (cnt_r == CNT_ONE);
    end

    // Next-state decode; accept in IDLE or DONE, finish on the last digit.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    finish_s     = 1'b1;
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Datapath: load operands on accept, iterate one digit per cycle in RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_r <= {EXT_W{1'b0}};
            acc_r   <= {ACC_W{1'b0}};
            y_m1_r  <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            mcand_r <= extend_operand(multiplicand, is_signed);
            acc_r   <= {{EXT_W{1'b0}}, extend_operand(multiplier, is_signed)};
            y_m1_r  <= 1'b0;
            cnt_r   <= CNT_START;
        end else if (state_r == ST_RUN) begin
            acc_r   <= acc_step_s;
            y_m1_r  <= y_m1_step_s;
            cnt_r   <= cnt_r - CNT_ONE;
        end else begin
            mcand_r <= mcand_r;
            acc_r   <= acc_r;
            y_m1_r  <= y_m1_r;
            cnt_r   <= cnt_r;
        end
    end

    // Registered outputs: product only moves on completion; busy mirrors RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            product_r <= {(2*WIDTH){1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            if (finish_s) begin
                product_r <= acc_step_s[2*WIDTH-1:0];
            end else begin
                product_r <= product_r;
            end
            busy_r <= (next_state_s == ST_RUN);
            done_r <= finish_s;
        end
    end

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Self-checking bench for booth_r4_multiplier: 8-bit and 16-bit instances,
// a table of directed vectors, hand-written back-to-back and reset sequences,
// and randomised operands checked against a plain-arithmetic reference.
module tb_booth_r4_multiplier;

    logic        clk = 1'b0;
    logic        reset;

    logic        s8_start;
    logic        s8_sgn;
    logic [7:0]  s8_a;
    logic [7:0]  s8_b;
    logic [15:0] p8;
    logic        busy8;
    logic        done8;

    logic        s16_start;
    logic        s16_sgn;
    logic [15:0] s16_a;
    logic [15:0] s16_b;
    logic [31:0] p16;
    logic        busy16;
    logic        done16;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          w;
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vq[$];

    booth_r4_multiplier #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .start        (s8_start),
        .is_signed    (s8_sgn),
        .multiplicand (s8_a),
        .multiplier   (s8_b),
        .product      (p8),
        .busy         (busy8),
        .done         (done8)
    );

    booth_r4_multiplier #(.WIDTH(16)) dut16 (
        .clk          (clk),
        .reset        (reset),
        .start        (s16_start),
        .is_signed    (s16_sgn),
        .multiplicand (s16_a),
        .multiplier   (s16_b),
        .product      (p16),
        .busy         (busy16),
        .done         (done16)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_mul(input int w, input logic sgn,
                                            input logic [15:0] a, input logic [15:0] b);
        longint av;
        longint bv;
        longint p;
        logic [63:0] mask;
        if (w == 8) begin
            if (sgn) begin
                av = longint'($signed(a[7:0]));
                bv = longint'($signed(b[7:0]));
            end else begin
                av = longint'(a[7:0]);
                bv = longint'(b[7:0]);
            end
        end else begin
            if (sgn) begin
                av = longint'($signed(a));
                bv = longint'($signed(b));
            end else begin
                av = longint'(a);
                bv = longint'(b);
            end
        end
        p = av * bv;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 32'(64'(p) & mask);
    endfunction

    function automatic logic [31:0] get_prod(input int w);
        return (w == 8) ? {16'h0000, p8} : p16;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 8) ? busy8 : busy16;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 8) ? done8 : done16;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int w, input logic st, input logic sgn,
                         input logic [15:0] a, input logic [15:0] b);
        if (w == 8) begin
            s8_start = st;
            s8_sgn   = sgn;
            s8_a     = a[7:0];
            s8_b     = b[7:0];
        end else begin
            s16_start = st;
            s16_sgn   = sgn;
            s16_a     = a;
            s16_b     = b;
        end
    endtask

    task automatic add_vec(input int w, input logic sgn, input logic [15:0] a,
                           input logic [15:0] b, input logic [31:0] exp, input string name);
        vec_t v;
        v.w = w; v.sgn = sgn; v.a = a; v.b = b; v.exp = exp; v.name = name;
        vq.push_back(v);
    endtask

    // One full transaction with latency, busy, pulse-width and hold checks.
    task automatic run_op(input int w, input logic sgn, input logic [15:0] a,
                          input logic [15:0] b, input logic [31:0] exp, input string name);
        int          edges;
        int          busy_cnt;
        int          overlap;
        int          early;
        int          n_dig;
        logic        got;
        logic [31:0] prev;
        n_dig = (w + 2) / 2;
        @(negedge clk);
        prev = get_prod(w);
        drive(w, 1'b1, sgn, a, b);
        @(negedge clk);
        // Accepted on the edge just passed; scramble inputs to prove they are latched.
        drive(w, 1'b0, ~sgn, 16'($urandom), 16'($urandom));
        edges = 0; busy_cnt = 0; overlap = 0; early = 0; got = 1'b0;
        while (!got && edges < 40) begin
            if (get_busy(w)) busy_cnt++;
            if (get_prod(w) !== prev) early++;
            @(negedge clk);
            edges++;
            if (get_busy(w) && get_done(w)) overlap++;
            if (get_done(w)) got = 1'b1;
        end
        check({name, "/timeout"}, 32'(got), 32'd1);
        check({name, "/latency"}, 32'(edges), 32'(n_dig));
        check({name, "/product"}, get_prod(w), exp);
        check({name, "/busy_cycles"}, 32'(busy_cnt), 32'(n_dig));
        check({name, "/busy_done_overlap"}, 32'(overlap), 32'd0);
        check({name, "/product_hold"}, 32'(early), 32'd0);
        @(negedge clk);
        check({name, "/done_one_cycle"}, 32'(get_done(w)), 32'd0);
        check({name, "/idle_busy"}, 32'(get_busy(w)), 32'd0);
    endtask

    initial begin
        int   edges;
        int   done_seen;
        logic got;
        logic sgn;
        logic [15:0] ra;
        logic [15:0] rb;

        reset = 1'b1;
        drive(8, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(16, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset/p8", {16'h0000, p8}, 32'h0);
        check("reset/busy8", 32'(busy8), 32'd0);
        check("reset/done8", 32'(done8), 32'd0);
        check("reset/p16", p16, 32'h0);
        check("reset/busy16", 32'(busy16), 32'd0);
        check("reset/done16", 32'(done16), 32'd0);
        reset = 1'b0;

        // Directed vector table.
        add_vec(8,  1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01, "u8_ff_ff");
        add_vec(8,  1'b1, 16'h0080, 16'h0080, 32'h00004000, "s8_min_min");
        add_vec(8,  1'b1, 16'h00F9, 16'h000D, 32'h0000FFA5, "s8_m7_13");
        add_vec(8,  1'b0, 16'h000E, 16'h000D, 32'h000000B6, "u8_14_13");
        add_vec(8,  1'b0, 16'h0018, 16'h0022, 32'h00000330, "u8_24_34");
        add_vec(8,  1'b0, 16'h0080, 16'h0080, 32'h00004000, "u8_80_80");
        add_vec(8,  1'b1, 16'h007F, 16'h0080, 32'h0000C080, "s8_max_min");
        add_vec(8,  1'b1, 16'h00FF, 16'h00FF, 32'h00000001, "s8_m1_m1");
        add_vec(8,  1'b1, 16'h0001, 16'h0080, 32'h0000FF80, "s8_1_min");
        add_vec(8,  1'b0, 16'h0000, 16'h00AB, 32'h00000000, "u8_zero");
        add_vec(16, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "u16_max");
        add_vec(16, 1'b1, 16'h8000, 16'h7FFF, 32'hC0008000, "s16_min_max");
        add_vec(16, 1'b1, 16'h8000, 16'h8000, 32'h40000000, "s16_min_min");
        add_vec(16, 1'b1, 16'hFFFF, 16'h0002, 32'hFFFFFFFE, "s16_m1_2");
        foreach (vq[i]) begin
            run_op(vq[i].w, vq[i].sgn, vq[i].a, vq[i].b, vq[i].exp, vq[i].name);
        end

        // Back-to-back: start held high, second op accepted from DONE.
        @(negedge clk);
        drive(8, 1'b1, 1'b0, 16'd14, 16'd13);
        @(negedge clk);
        drive(8, 1'b1, 1'b0, 16'd24, 16'd34);
        edges = 0; got = 1'b0;
        while (!got && edges < 40) begin
            @(negedge clk);
            edges++;
            got = done8;
        end
        check("b2b/first_latency", 32'(edges), 32'd5);
        check("b2b/first_product", {16'h0000, p8}, 32'h00B6);
        @(negedge clk);
        check("b2b/done_dropped", 32'(done8), 32'd0);
        check("b2b/busy_again", 32'(busy8), 32'd1);
        check("b2b/product_held", {16'h0000, p8}, 32'h00B6);
        drive(8, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
        edges = 1; got = 1'b0;
        while (!got && edges < 40) begin
            @(negedge clk);
            edges++;
            got = done8;
        end
        check("b2b/second_spacing", 32'(edges), 32'd6);
        check("b2b/second_product", {16'h0000, p8}, 32'h0330);
        @(negedge clk);
        check("b2b/idle_busy", 32'(busy8), 32'd0);
        check("b2b/idle_done", 32'(done8), 32'd0);

        // Reset asserted off-edge in the middle of a run.
        @(negedge clk);
        drive(8, 1'b1, 1'b0, 16'd101, 16'd102);
        @(negedge clk);
        drive(8, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
        @(negedge clk);
        @(negedge clk);
        check("midreset/busy_before", 32'(busy8), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("midreset/p8", {16'h0000, p8}, 32'h0);
        check("midreset/busy8", 32'(busy8), 32'd0);
        check("midreset/done8", 32'(done8), 32'd0);
        check("midreset/p16", p16, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done8) done_seen++;
        end
        check("midreset/no_done", 32'(done_seen), 32'd0);
        check("midreset/idle_busy", 32'(busy8), 32'd0);
        run_op(8, 1'b0, 16'd101, 16'd102, ref_mul(8, 1'b0, 16'd101, 16'd102), "after_reset");

        // Randomised cross-check against the reference model.
        for (int i = 0; i < 2500; i++) begin
            sgn = 1'($urandom_range(0, 1));
            ra  = 16'($urandom) & 16'h00FF;
            rb  = 16'($urandom) & 16'h00FF;
            run_op(8, sgn, ra, rb, ref_mul(8, sgn, ra, rb), "rand8");
            sgn = 1'($urandom_range(0, 1));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            run_op(16, sgn, ra, rb, ref_mul(16, sgn, ra, rb), "rand16");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
